// File: rtl/sr_pulse_pkg.sv
// Shared types and default parameters for the set/reset pulse front-end.
package sr_pulse_pkg;

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} sr_state_t;

  localparam int unsigned DEBOUNCE_DEF = 4;
  localparam int unsigned GAP_DEF      = 2;
  localparam int unsigned CNT_W_DEF    = 8;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, debounce filter and debounced-rising-edge event for one request line.
module sr_debounce
  import sr_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic ev_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Toggle the accepted level only after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    sync1_d      = din;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ev_c = stable_q & ~stable_dly_q;

endmodule

// File: rtl/sr_pulse_gen.sv
// Turns debounced set/clear requests into mutually exclusive, gap-spaced s/r pulses.
module sr_pulse_gen #(
  parameter int unsigned DEBOUNCE = sr_pulse_pkg::DEBOUNCE_DEF,
  parameter int unsigned GAP      = sr_pulse_pkg::GAP_DEF,
  parameter int unsigned CNT_W    = sr_pulse_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_req,
  input  logic             clr_req,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);
  import sr_pulse_pkg::*;

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned SW = CNT_W + 2;

  logic ev_s_c, ev_r_c;

  sr_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_set (
    .clk (clk),
    .rst (rst),
    .din (set_req),
    .ev_c(ev_s_c)
  );

  sr_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_clr (
    .clk (clk),
    .rst (rst),
    .din (clr_req),
    .ev_c(ev_r_c)
  );

  sr_state_t        state_q, state_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             pend_s_q, pend_s_d;
  logic             pend_r_q, pend_r_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             take_s, take_r, discard;
  logic             merge_s, merge_r;
  logic [SW-1:0]    drop_sum;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = '0;
    take_s    = 1'b0;
    take_r    = 1'b0;
    discard   = 1'b0;
    case (state_q)
      // Clear has priority; a simultaneously pending set is thrown away.
      IDLE: begin
        if (pend_r_q) begin
          state_d = PULSE_R;
          take_r  = 1'b1;
          if (pend_s_q) begin
            take_s  = 1'b1;
            discard = 1'b1;
          end
        end else if (pend_s_q) begin
          state_d = PULSE_S;
          take_s  = 1'b1;
        end
      end
      PULSE_S, PULSE_R: state_d = (GAP > 0) ? sr_pulse_pkg::GAP : IDLE;
      sr_pulse_pkg::GAP: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // An event landing on an already-pending flag is merged and counted as dropped.
    merge_s  = ev_s_c & pend_s_q;
    merge_r  = ev_r_c & pend_r_q;
    pend_s_d = (pend_s_q | ev_s_c) & ~take_s;
    pend_r_d = (pend_r_q | ev_r_c) & ~take_r;

    drop_sum = SW'(drop_q) + SW'(merge_s) + SW'(merge_r) + SW'(discard);
    if (drop_sum > SW'({CNT_W{1'b1}})) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum[CNT_W-1:0];
    end

    s_d    = (state_d == PULSE_S);
    r_d    = (state_d == PULSE_R);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      pend_s_q  <= 1'b0;
      pend_r_q  <= 1'b0;
      drop_q    <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pend_s_q  <= pend_s_d;
      pend_r_q  <= pend_r_d;
      drop_q    <= drop_d;
      s_q       <= s_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: default instance plus a long-GAP instance for merging.
module tb_sr_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_req, clr_req, s, r, busy;
  logic [7:0] drop_cnt;
  logic       set2, clr2, s2, r2, busy2;
  logic [7:0] drop2;

  always #5 clk = ~clk;

  sr_pulse_gen u_dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .busy(busy), .drop_cnt(drop_cnt)
  );

  sr_pulse_gen #(.DEBOUNCE(4), .GAP(12), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .set_req(set2), .clr_req(clr2),
    .s(s2), .r(r2), .busy(busy2), .drop_cnt(drop2)
  );

  typedef struct {
    bit is_r;
    int cyc;
    int drop;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin
    if (s || r) begin : mon1
      exp_t e;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected_pulse: got s=%0b r=%0b at cycle %0d, expected no pulse", s, r, cyc);
      end else begin
        e = q1.pop_front();
        chk("d1_pulse_r", int'(r), int'(e.is_r));
        chk("d1_pulse_s", int'(s), int'(!e.is_r));
        chk("d1_pulse_cycle", cyc, e.cyc);
        chk("d1_pulse_drop", int'(drop_cnt), e.drop);
      end
    end
  end

  // Monitor for the long-GAP instance.
  always @(negedge clk) begin
    if (s2 || r2) begin : mon2
      exp_t e;
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d2_unexpected_pulse: got s=%0b r=%0b at cycle %0d, expected no pulse", s2, r2, cyc);
      end else begin
        e = q2.pop_front();
        chk("d2_pulse_r", int'(r2), int'(e.is_r));
        chk("d2_pulse_s", int'(s2), int'(!e.is_r));
        chk("d2_pulse_cycle", cyc, e.cyc);
        chk("d2_pulse_drop", int'(drop2), e.drop);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0; set2 = 1'b0; clr2 = 1'b0;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      chk("rst_s", int'(s), 0);
      chk("rst_r", int'(r), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_drop", int'(drop_cnt), 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_drop", int'(drop_cnt), 0);
    end

    // Single set: s one cycle at E0+7, busy for E0+7..E0+9
    e0 = cyc + 1;
    set_req = 1'b1;
    q1.push_back('{is_r: 1'b0, cyc: e0 + 7, drop: 0});
    repeat (20) begin
      @(negedge clk);
      n = cyc - e0;
      if (n >= 5 && n <= 11) chk("single_busy", int'(busy), int'(n >= 7 && n <= 9));
    end
    set_req = 1'b0;
    step(15);

    // Glitch of 3 cycles is rejected; 5 cycles gives one r
    clr_req = 1'b1;
    step(3);
    clr_req = 1'b0;
    step(15);
    chk("glitch_drop", int'(drop_cnt), 0);
    e0 = cyc + 1;
    clr_req = 1'b1;
    q1.push_back('{is_r: 1'b1, cyc: e0 + 7, drop: 0});
    step(5);
    clr_req = 1'b0;
    step(15);

    // Simultaneous set and clear: r wins, set discarded
    e0 = cyc + 1;
    set_req = 1'b1;
    clr_req = 1'b1;
    q1.push_back('{is_r: 1'b1, cyc: e0 + 7, drop: 1});
    step(12);
    chk("simul_drop", int'(drop_cnt), 1);
    set_req = 1'b0;
    clr_req = 1'b0;
    step(15);

    // Spacing: clear event lands during GAP, served after the IDLE decision cycle
    e0 = cyc + 1;
    set_req = 1'b1;
    q1.push_back('{is_r: 1'b0, cyc: e0 + 7, drop: 1});
    step(2);
    clr_req = 1'b1;
    q1.push_back('{is_r: 1'b1, cyc: e0 + 11, drop: 1});
    step(18);
    set_req = 1'b0;
    clr_req = 1'b0;
    step(15);

    // Merge on the long-GAP instance: second set event while pend_s held
    e0 = cyc + 1;
    clr2 = 1'b1;
    q2.push_back('{is_r: 1'b1, cyc: e0 + 7, drop: 0});
    step(1);
    set2 = 1'b1;
    step(5);
    set2 = 1'b0;
    step(5);
    chk("merge_busy_in_gap", int'(busy2), 1);
    set2 = 1'b1;
    q2.push_back('{is_r: 1'b0, cyc: e0 + 21, drop: 1});
    step(25);
    chk("merge_drop", int'(drop2), 1);
    set2 = 1'b0;
    clr2 = 1'b0;
    step(15);

    // Reset one cycle after pend_s sets: pulse never appears
    e0 = cyc + 1;
    set_req = 1'b1;
    step(7);
    rst = 1'b1;
    set_req = 1'b0;
    step(1);
    chk("midrst_s", int'(s), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    step(12);
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_drop", int'(drop_cnt), 0);
    e0 = cyc + 1;
    set_req = 1'b1;
    q1.push_back('{is_r: 1'b0, cyc: e0 + 7, drop: 0});
    step(12);
    set_req = 1'b0;
    step(15);

    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
      step(1);
      n++;
    end
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
